wb_regfile: RTL

//   Write-back stage and architectural register file of the 3-stage pipeline.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/fwd_mux.sv | 33 +++
 rtl/wb_regfile.sv | 77 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the 3-stage core.
// Used by the write-back/register-file block and the stage registers.
package pipe_pkg;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NREG     = 2 ** AW;
    localparam int ZERO_IDX = 0;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] rsel_t;

endpackage

// File: rtl/fwd_mux.sv
// Read-port priority select: hardwired zero, EX forward, WB bypass, then storage.
// Purely combinational; one instance per read port.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DW       = pipe_pkg::DW,
    parameter int AW       = pipe_pkg::AW,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] sel,
    input  logic          ex_en,
    input  logic [AW-1:0] ex_sel,
    input  logic [DW-1:0] ex_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_sel,
    input  logic [DW-1:0] wb_data,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] data
);

    // NOTE: data gets a default before the priority chain so no path leaves it unassigned (no latch).
    always_comb begin
        data = mem_data;
        if (ZERO_REG != 0 && sel == AW'(ZERO_IDX)) begin
            data = '0;
        end else if (ex_en && ex_sel == sel) begin
            data = ex_data;
        end else if (wb_en && wb_sel == sel) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: commits stage-3 results into the register file, serves two
// forwarded read ports to decode, and counts retired write-backs.
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int DW       = pipe_pkg::DW,
    parameter int AW       = pipe_pkg::AW,
    parameter int ZERO_REG = 1,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] wb_sel,
    input  logic          wb_en,
    input  logic [DW-1:0] ex_data,
    input  logic [AW-1:0] ex_sel,
    input  logic          ex_en,
    input  logic [AW-1:0] ra_sel,
    input  logic [AW-1:0] rb_sel,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic [CW-1:0] retire_cnt
);

    localparam int N = 2 ** AW;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] ra_fwd;
    logic [DW-1:0] rb_fwd;

    // NOTE: the whole array is reset because software relies on every register
    // reading zero after reset; this forces flops rather than a RAM macro.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            retire_cnt <= '0;
        end else if (wb_en) begin
            retire_cnt <= retire_cnt + CW'(1);
            if (ZERO_REG == 0 || wb_sel != AW'(ZERO_IDX)) begin
                mem[wb_sel] <= wb_data;
            end
        end
    end

    fwd_mux #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .sel      (ra_sel),
        .ex_en    (ex_en),
        .ex_sel   (ex_sel),
        .ex_data  (ex_data),
        .wb_en    (wb_en),
        .wb_sel   (wb_sel),
        .wb_data  (wb_data),
        .mem_data (mem[ra_sel]),
        .data     (ra_fwd)
    );

    fwd_mux #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .sel      (rb_sel),
        .ex_en    (ex_en),
        .ex_sel   (ex_sel),
        .ex_data  (ex_data),
        .wb_en    (wb_en),
        .wb_sel   (wb_sel),
        .wb_data  (wb_data),
        .mem_data (mem[rb_sel]),
        .data     (rb_fwd)
    );

    // Reads are forced to zero during reset so decode never sees stale forwards.
    assign ra_data = rst ? '0 : ra_fwd;
    assign rb_data = rst ? '0 : rb_fwd;

endmodule
